// File: rtl/fg_trigger_responder.sv
// Frame-grabber emulator for the calibration handshake.
// Emits a train of fg_signal pulses. For each frame it measures the latency
// from fg_signal to the returned trigger and the width of that trigger.
// It also keeps frame, timeout and early-trigger statistics.
`timescale 1ns/1ps
module fg_trigger_responder #(
    parameter int FG_PERIOD    = 1000,
    parameter int FG_PULSE_LEN = 10,
    parameter int TRIG_TIMEOUT = 2000000,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset_signal,
    input  logic             start_signal,
    input  logic             stop_signal,
    input  logic [15:0]      frame_count,
    input  logic             trigger_in,
    output logic             fg_signal,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] latency,
    output logic             latency_valid,
    output logic [CNT_W-1:0] trig_len,
    output logic [15:0]      frames_done,
    output logic [15:0]      timeout_count,
    output logic             early_err
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] FG_PULSE    = 3'd1;
    localparam logic [2:0] WAIT_TRIG   = 3'd2;
    localparam logic [2:0] MEASURE_LEN = 3'd3;
    localparam logic [2:0] GAP         = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(FG_PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(FG_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TRIG_TIMEOUT);

    logic [2:0]       state;
    logic [15:0]      frames_left;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic [CNT_W-1:0] width_inc;

    logic trig_meta, trig_sync, trig_hist;
    logic start_hist, stop_hist;
    logic trig_rise, trig_fall, start_rise, stop_rise;

    // Two-flop synchroniser on the returned trigger, plus history bits for all edge detectors.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            trig_meta  <= 1'b0;
            trig_sync  <= 1'b0;
            trig_hist  <= 1'b0;
            start_hist <= 1'b0;
            stop_hist  <= 1'b0;
        end else begin
            trig_meta  <= trigger_in;
            trig_sync  <= trig_meta;
            trig_hist  <= trig_sync;
            start_hist <= start_signal;
            stop_hist  <= stop_signal;
        end
    end

    assign trig_rise  =  trig_sync & ~trig_hist;
    assign trig_fall  = ~trig_sync &  trig_hist;
    assign start_rise =  start_signal & ~start_hist;
    assign stop_rise  =  stop_signal  & ~stop_hist;

    // The cycle in which the rise is seen counts as the first high cycle of the trigger.
    assign width_inc = width_cnt + CNT_ONE;

    // Frame-train sequencer, measurement counters and statistics.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state         <= IDLE;
            fg_signal     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            latency       <= '0;
            latency_valid <= 1'b0;
            trig_len      <= '0;
            frames_done   <= '0;
            timeout_count <= '0;
            early_err     <= 1'b0;
            frames_left   <= '0;
            period_cnt    <= '0;
            lat_cnt       <= '0;
            width_cnt     <= '0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in this block overrides these defaults, which makes the pulses one cycle long.
            done          <= 1'b0;
            latency_valid <= 1'b0;
            if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_ONE;
            if (lat_cnt < TIMEOUT)     lat_cnt    <= lat_cnt + CNT_ONE;

            if (stop_rise && state != IDLE) begin
                // Abort: statistics stay as they are.
                state     <= IDLE;
                fg_signal <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_rise && !stop_rise) begin
                            if (frame_count != 16'd0) begin
                                frames_left   <= frame_count;
                                frames_done   <= '0;
                                timeout_count <= '0;
                                early_err     <= 1'b0;
                                period_cnt    <= '0;
                                lat_cnt       <= '0;
                                fg_signal     <= 1'b1;
                                busy          <= 1'b1;
                                state         <= FG_PULSE;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    FG_PULSE: begin
                        if (trig_rise) early_err <= 1'b1;
                        if (period_cnt >= PULSE_LAST) begin
                            fg_signal <= 1'b0;
                            state     <= WAIT_TRIG;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_rise) begin
                            latency       <= lat_cnt;
                            latency_valid <= 1'b1;
                            width_cnt     <= '0;
                            state         <= MEASURE_LEN;
                        end else if (lat_cnt >= TIMEOUT) begin
                            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                            state <= GAP;
                        end
                    end
                    MEASURE_LEN: begin
                        if (trig_fall || width_inc >= TIMEOUT) begin
                            trig_len <= width_inc;
                            state    <= GAP;
                        end else begin
                            width_cnt <= width_inc;
                        end
                    end
                    GAP: begin
                        // An overrunning measurement leaves period_cnt past the end, so GAP exits at once.
                        if (period_cnt >= PERIOD_LAST) begin
                            if (frames_done != 16'hFFFF) frames_done <= frames_done + 16'd1;
                            frames_left <= frames_left - 16'd1;
                            if (frames_left == 16'd1) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                period_cnt <= '0;
                                lat_cnt    <= '0;
                                fg_signal  <= 1'b1;
                                state      <= FG_PULSE;
                            end
                        end
                    end
                    default: begin
                        fg_signal <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fg_trigger_responder.sv
// Self-checking bench for fg_trigger_responder. Expected values come from a
// per-frame timing model built from the handshake rules.
`timescale 1ns/1ps
module tb_fg_trigger_responder;

    localparam int P  = 50;
    localparam int L  = 4;
    localparam int T  = 30;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset_signal;
    logic          start_signal;
    logic          stop_signal;
    logic [15:0]   frame_count;
    logic          trigger_in;
    logic          fg_signal;
    logic          busy;
    logic          done;
    logic [CW-1:0] latency;
    logic          latency_valid;
    logic [CW-1:0] trig_len;
    logic [15:0]   frames_done;
    logic [15:0]   timeout_count;
    logic          early_err;

    fg_trigger_responder #(
        .FG_PERIOD(P), .FG_PULSE_LEN(L), .TRIG_TIMEOUT(T), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset_signal(reset_signal), .start_signal(start_signal),
        .stop_signal(stop_signal), .frame_count(frame_count), .trigger_in(trigger_in),
        .fg_signal(fg_signal), .busy(busy), .done(done), .latency(latency),
        .latency_valid(latency_valid), .trig_len(trig_len), .frames_done(frames_done),
        .timeout_count(timeout_count), .early_err(early_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    // Two trigger windows in absolute cycles: the current frame and the previous one (a trigger may overrun).
    int w0_on = 0, w0_off = 0, w1_on = 0, w1_off = 0;
    int plan_k[16];
    int plan_w[16];
    // Reference statistics.
    int m_latency = 0, m_trig_len = 0, m_timeouts = 0, m_frames = 0;
    bit m_early = 1'b0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic drive_trig();
        trigger_in = (cyc >= w0_on && cyc < w0_off) || (cyc >= w1_on && cyc < w1_off);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        drive_trig();
    endtask

    // Raw trigger rises k cycles after fg rise and stays high w cycles (w=0: no trigger).
    // The synchronised edge is seen at r=k+2. An edge inside the pulse is early; after the timeout it is ignored.
    function automatic void model_frame(input int k, input int w, output bit early, output bit has_lat,
                                        output int lat, output int tl, output int flen);
        int r;
        int gap_in;
        early = 1'b0; has_lat = 1'b0; lat = 0; tl = 0; gap_in = T + 1;
        if (w > 0) begin
            r = k + 2;
            if (r < L) early = 1'b1;
            else if (r <= T) begin
                has_lat = 1'b1;
                lat     = r;
                tl      = (w < T) ? w : T;
                gap_in  = r + tl + 1;
            end
        end
        flen = ((gap_in > P - 1) ? gap_in : P - 1) + 1;
    endfunction

    task automatic run_train(input int n, input int stop_frame, input int stop_t);
        int t, fg_hi, lv_cnt, lv_t, lat_e, tl_e, flen_e;
        bit early_e, has_lat, prev_fg, last;
        w0_on = 0; w0_off = 0; w1_on = 0; w1_off = 0;
        drive_trig();
        frame_count  = 16'(n);
        start_signal = 1'b1;
        step();
        start_signal = 1'b0;
        m_frames = 0; m_timeouts = 0; m_early = 1'b0;
        check("fg_after_start", fg_signal, 1);
        check("busy_after_start", busy, 1);
        check("early_cleared", early_err, 0);
        check("frames_cleared", frames_done, 0);
        check("timeouts_cleared", timeout_count, 0);
        for (int i = 0; i < n; i++) begin
            w0_on = w1_on; w0_off = w1_off;
            w1_on = cyc + plan_k[i]; w1_off = w1_on + plan_w[i];
            drive_trig();
            model_frame(plan_k[i], plan_w[i], early_e, has_lat, lat_e, tl_e, flen_e);
            fg_hi = 0; lv_cnt = 0; lv_t = -1; t = 0;
            while (t < 400) begin
                if (fg_signal) fg_hi++;
                if (latency_valid) begin
                    lv_cnt++;
                    lv_t = t;
                    check("latency_at_valid", latency, lat_e);
                end
                if (i == stop_frame && t == stop_t) begin
                    stop_signal = 1'b1;
                    step();
                    stop_signal = 1'b0;
                    check("stop_fg_low", fg_signal, 0);
                    check("stop_busy_low", busy, 0);
                    check("stop_done", done, 1);
                    check("stop_frames_done", frames_done, m_frames);
                    check("stop_timeouts", timeout_count, m_timeouts);
                    check("stop_latency", latency, m_latency);
                    check("stop_trig_len", trig_len, m_trig_len);
                    step();
                    check("stop_done_pulse", done, 0);
                    check("stop_stays_idle", busy, 0);
                    return;
                end
                start_signal = (i == 0 && t == 20);
                prev_fg = fg_signal;
                step();
                t++;
                if ((fg_signal && !prev_fg) || done) break;
            end
            start_signal = 1'b0;
            last = (i == n - 1);
            check("fg_high_cycles", fg_hi, L);
            check("frame_len", t, flen_e);
            check("latency_valid_pulses", lv_cnt, has_lat);
            if (has_lat) begin
                check("latency_valid_time", lv_t, lat_e + 1);
                m_latency  = lat_e;
                m_trig_len = tl_e;
            end else if (m_timeouts < 65535) begin
                m_timeouts++;
            end
            if (early_e) m_early = 1'b1;
            m_frames++;
            check("latency", latency, m_latency);
            check("trig_len", trig_len, m_trig_len);
            check("frames_done", frames_done, m_frames);
            check("timeout_count", timeout_count, m_timeouts);
            check("early_err", early_err, m_early);
            check("done_at_boundary", done, last);
            check("busy_at_boundary", busy, !last);
        end
        step();
        check("done_one_cycle", done, 0);
        check("idle_after_train", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fg"}, fg_signal, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_latency"}, latency, 0);
        check({tag, "_lat_valid"}, latency_valid, 0);
        check({tag, "_trig_len"}, trig_len, 0);
        check({tag, "_frames"}, frames_done, 0);
        check({tag, "_timeouts"}, timeout_count, 0);
        check({tag, "_early"}, early_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int fg_any;
        reset_signal = 1'b1; start_signal = 1'b0; stop_signal = 1'b0;
        frame_count = 16'd0; trigger_in = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_signal = 1'b0;
        step();
        check("idle_after_reset", busy, 0);

        // Single frame with a well-behaved trigger.
        plan_k[0] = 10; plan_w[0] = 6;
        run_train(1, -1, 0);
        check("single_latency", latency, 12);
        check("single_trig_len", trig_len, 6);

        // No trigger at all: three timeouts.
        for (int i = 0; i < 3; i++) begin plan_k[i] = 0; plan_w[i] = 0; end
        run_train(3, -1, 0);

        // Early trigger, then a fresh start clears the sticky flag.
        plan_k[0] = 1; plan_w[0] = 3;
        run_train(1, -1, 0);
        plan_k[0] = 10; plan_w[0] = 6;
        run_train(1, -1, 0);

        // Stop during the second frame's wait for the trigger.
        for (int i = 0; i < 10; i++) begin plan_k[i] = 0; plan_w[i] = 0; end
        plan_k[0] = 10; plan_w[0] = 6;
        run_train(10, 1, 15);

        // Overrun: the trigger is held well past the width limit and into the next frame.
        plan_k[0] = 18; plan_w[0] = 45;
        plan_k[1] = 0;  plan_w[1] = 0;
        run_train(2, -1, 0);

        // Randomised trains.
        for (int r = 0; r < 5; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                plan_k[i] = int'($urandom_range(0, 35));
                plan_w[i] = int'($urandom_range(1, 45 - plan_k[i]));
                if ($urandom_range(0, 4) == 0) plan_w[i] = 0;
            end
            run_train(n, -1, 0);
        end

        // Asynchronous reset while measuring the trigger width.
        w0_on = 0; w0_off = 0; w1_on = 0; w1_off = 0;
        frame_count  = 16'd1;
        start_signal = 1'b1;
        step();
        start_signal = 1'b0;
        w1_on = cyc + 10; w1_off = cyc + 30;
        drive_trig();
        repeat (16) step();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_latency", latency, 12);
        #3 reset_signal = 1'b1;
        #1;
        check_all_zero("async_reset");
        w1_on = 0; w1_off = 0;
        drive_trig();
        step();
        step();
        reset_signal = 1'b0;
        step();
        check_all_zero("post_reset");
        frame_count  = 16'd0;
        start_signal = 1'b1;
        step();
        start_signal = 1'b0;
        check("zero_frames_done", done, 1);
        check("zero_frames_busy", busy, 0);
        fg_any = int'(fg_signal);
        for (int i = 0; i < 6; i++) begin
            step();
            if (fg_signal) fg_any = 1;
        end
        check("zero_frames_no_fg", fg_any, 0);
        check("zero_frames_done_pulse", done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fg_trigger_responder.md
Name: fg_trigger_responder

Overview:
- Emulates the frame-grabber end of the calibration handshake so that the trigger-generating FSMs can be exercised on the bench and in system self-test.
- On an armed start it emits a programmable train of fg_signal pulses, watches the returned trigger line, and measures per frame the fg-to-trigger latency and the trigger width.
- Counts frames, timeouts and early triggers, and reports them to the control/readout logic.

Parameters:
- FG_PERIOD, 1000: cycles from one fg_signal rising edge to the next.
- FG_PULSE_LEN, 10: cycles fg_signal is held high per frame; must be ≥1 and <FG_PERIOD.
- TRIG_TIMEOUT, 2000000: maximum cycles for the latency counter and for the width counter.
- CNT_W, 32: width of the latency and width counters.

Ports:
- clock  in  1  system clock.
- reset_signal  in  1  asynchronous, active-high reset.
- start_signal  in  1  rising edge arms a frame train (synchronous, edge-detected).
- stop_signal  in  1  rising edge aborts the train (synchronous, edge-detected).
- frame_count  in  16  number of frames, sampled at the start edge.
- trigger_in  in  1  asynchronous returned trigger (output_trigger of the DUT).
- fg_signal  out  1  emulated frame-grabber opto pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the train completes or is stopped.
- latency  out  CNT_W  last measured fg-to-trigger latency.
- latency_valid  out  1  one-cycle pulse when latency updates.
- trig_len  out  CNT_W  last measured trigger high width, in cycles.
- frames_done  out  16  frames completed in the current train.
- timeout_count  out  16  frames with no trigger inside TRIG_TIMEOUT.
- early_err  out  1  sticky; set by a trigger rising edge during FG_PULSE.

Behaviour:
- Reset: asynchronous, active-high. All outputs, counters and synchronisers clear to 0; state goes to IDLE.
- Input conditioning:
  - trigger_in passes through a 2-flop synchroniser, then a history-register edge detector.
  - start_signal and stop_signal pass through a history-register edge detector only.
  - Reported latency includes the fixed 2-cycle synchroniser delay: trigger_in rising k cycles after fg_signal rises reports k+2.
- States: IDLE, FG_PULSE, WAIT_TRIG, MEASURE_LEN, GAP.
- IDLE:
  - On a start edge with frame_count≠0: latch frame_count into frames_left; clear frames_done, timeout_count and early_err; go to FG_PULSE.
  - On a start edge with frame_count=0: pulse done next cycle and stay in IDLE.
- FG_PULSE:
  - fg_signal=1.
  - Both period_cnt and lat_cnt are 0 in the first cycle and increment every cycle.
  - After FG_PULSE_LEN cycles go to WAIT_TRIG.
  - A synced trigger rising edge here sets early_err and is otherwise ignored.
- WAIT_TRIG:
  - fg_signal=0.
  - On a synced rising edge: latency←lat_cnt, pulse latency_valid, clear width counter, go to MEASURE_LEN.
  - Else, if lat_cnt reaches TRIG_TIMEOUT: timeout_count+1 (saturating), go to GAP.
  - If both happen in the same cycle, the edge wins.
- MEASURE_LEN:
  - Width counter increments each cycle.
  - On a synced falling edge, or when the counter reaches TRIG_TIMEOUT: trig_len←counter, go to GAP.
- GAP:
  - When period_cnt ≥ FG_PERIOD−1: frames_done+1 and frames_left−1.
  - If frames_left was 1: pulse done and go to IDLE.
  - Otherwise go to FG_PULSE with both counters reset.
  - If measurement overran the period, GAP exits in its first cycle.
- Stop: a stop edge in any non-IDLE state goes to IDLE next cycle, drops fg_signal, pulses done, and leaves the statistics unchanged. Stop and start in the same cycle in IDLE: stop wins, no train starts.
- Start edges while busy are ignored.
- Counter widths: counters saturate and never wrap; frames_left is 16-bit.
- Reset mid-train: immediate return to IDLE with all outputs 0.

Test Plan:
Common settings: FG_PERIOD=50, FG_PULSE_LEN=4, TRIG_TIMEOUT=30.
1. Single frame: start with frame_count=1, DUT raises trigger_in 10 cycles after fg rise and holds it 6 cycles -> fg_signal high exactly 4 cycles; latency=12, one latency_valid pulse, trig_len=6; done at cycle 50 after fg rise; frames_done=1.
2. Timeout: frame_count=3, trigger_in held low -> three fg pulses 50 cycles apart; timeout_count=3, no latency_valid; done after the third period; busy low afterwards.
3. Early trigger: trigger_in rises 1 cycle after fg rise -> early_err=1; that frame times out (timeout_count=1); a second start clears early_err to 0.
4. Stop mid-train: frame_count=10, stop edge during the 2nd WAIT_TRIG -> fg_signal low, IDLE, done pulse one cycle later; frames_done=1; start edges while busy had no effect.
5. Reset mid-MEASURE_LEN: assert reset_signal asynchronously -> all outputs 0 before the next clock edge; after release a start with frame_count=0 gives a done pulse and no fg_signal.
6. Overrun: trigger held 45 cycles starting at latency 20 -> trig_len=30 (saturated at TRIG_TIMEOUT); the next fg pulse starts the cycle after GAP entry.
